// File: rtl/key_multi_ctrl.sv
// key_multi_ctrl -- parametrised multi-key front end.
// Each key is synchronised (2 flops), debounced by a per-key counter,
// and tracked by a small FSM that emits one-cycle press/release/long
// pulses. A registered LED action unit reacts to those pulses.
// Optional macro KEY_LONG_PRESS_EN: when defined, hold counters and
// long-press detection are built and LED actions fire on short release.
// When undefined, long_pulse is tied low and LED actions fire on press.
module key_multi_ctrl #(
    parameter int KEY_NUM  = 4,
    parameter int LED_NUM  = 3,
    parameter int DEB_CYC  = 1000000,
    parameter int LONG_CYC = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_pulse,
    output logic [KEY_NUM-1:0] release_pulse,
    output logic [KEY_NUM-1:0] long_pulse,
    output logic [LED_NUM-1:0] led
);

    localparam int               DEB_W    = $clog2(DEB_CYC);
    localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [KEY_NUM-1:0] KEY_ONE = KEY_NUM'(1);

`ifdef KEY_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } key_st_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1
    } key_st_e;
`endif

    // Isolate the lowest set bit so the lowest key index wins arbitration.
    function automatic logic [KEY_NUM-1:0] lowest_set(input logic [KEY_NUM-1:0] vec);
        lowest_set = vec & (~vec + KEY_ONE);
    endfunction

    logic [KEY_NUM-1:0] sync1_r;
    logic [KEY_NUM-1:0] sync2_r;
    logic [KEY_NUM-1:0] stable_s;
    logic [KEY_NUM-1:0] press_s;
    logic [KEY_NUM-1:0] release_s;
    logic [KEY_NUM-1:0] event_s;
    logic [KEY_NUM-1:0] win_s;
    logic               clear_s;
    logic [LED_NUM-1:0] led_r;
    logic [LED_NUM-1:0] led_nxt_s;
`ifdef KEY_LONG_PRESS_EN
    logic [KEY_NUM-1:0] long_s;
    logic [KEY_NUM-1:0] short_s;
`endif

    // Two-flop synchroniser for the asynchronous, active-low key pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {KEY_NUM{1'b1}};
            sync2_r <= {KEY_NUM{1'b1}};
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        logic [DEB_W-1:0] deb_cnt_r;
        logic             stable_r;
        logic             press_r;
        logic             release_r;
        logic             level_s;
        logic             differ_s;
        logic             accept_s;
        logic             acc_press_s;
        logic             acc_rel_s;
        key_st_e          state_r;
        key_st_e          state_nxt_s;

        // Synced level converted to 1 = pressed; accept once it has differed
        // from the stable level for DEB_CYC consecutive cycles.
        assign level_s     = ~sync2_r[k];
        assign differ_s    = (level_s != stable_r);
        assign accept_s    = differ_s && (deb_cnt_r == DEB_LAST);
        assign acc_press_s = accept_s & level_s;
        assign acc_rel_s   = accept_s & ~level_s;

        // Debounce counter and accepted (stable) key level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_r <= DEB_ZERO;
                stable_r  <= 1'b0;
            end else if (!differ_s) begin
                deb_cnt_r <= DEB_ZERO;
            end else if (accept_s) begin
                deb_cnt_r <= DEB_ZERO;
                stable_r  <= level_s;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
        end

        // Press/release pulses registered on the same edge as stable flips.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= acc_press_s;
                release_r <= acc_rel_s;
            end
        end

`ifdef KEY_LONG_PRESS_EN
        logic [HOLD_W-1:0] hold_r;
        logic [HOLD_W-1:0] hold_nxt_s;
        logic              short_r;
        logic              short_nxt_s;
        logic              long_r;
        logic              long_nxt_s;

        // Key FSM state, hold counter and short/long event registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                hold_r  <= HOLD_ZERO;
                short_r <= 1'b0;
                long_r  <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                hold_r  <= hold_nxt_s;
                short_r <= short_nxt_s;
                long_r  <= long_nxt_s;
            end
        end

        // Key FSM next state: short release vs. long hold detection.
        always_comb begin
            state_nxt_s = state_r;
            hold_nxt_s  = hold_r;
            short_nxt_s = 1'b0;
            long_nxt_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (acc_press_s) begin
                        state_nxt_s = ST_PRESSED;
                        hold_nxt_s  = HOLD_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (acc_rel_s) begin
                        state_nxt_s = ST_IDLE;
                        short_nxt_s = 1'b1;
                    end else if (hold_r == HOLD_LAST) begin
                        state_nxt_s = ST_LONG_HELD;
                        long_nxt_s  = 1'b1;
                    end else begin
                        hold_nxt_s = hold_r + HOLD_ONE;
                    end
                end
                ST_LONG_HELD: begin
                    if (acc_rel_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LONG_HELD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        assign short_s[k] = short_r;
        assign long_s[k]  = long_r;
`else
        // Key FSM state register (press/release tracking only).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_nxt_s;
            end
        end

        // Key FSM next state: follow accepted press and release.
        always_comb begin
            state_nxt_s = state_r;
            case (state_r)
                ST_IDLE: begin
                    if (acc_press_s) begin
                        state_nxt_s = ST_PRESSED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (acc_rel_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PRESSED;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
`endif

        assign stable_s[k]  = stable_r;
        assign press_s[k]   = press_r;
        assign release_s[k] = release_r;
    end

`ifdef KEY_LONG_PRESS_EN
    assign long_pulse = long_s;
    assign event_s    = short_s;
    assign clear_s    = |long_s;
`else
    assign long_pulse = {KEY_NUM{1'b0}};
    assign event_s    = press_s;
    assign clear_s    = 1'b0;
`endif

    assign key_state     = stable_s;
    assign press_pulse   = press_s;
    assign release_pulse = release_s;
    assign win_s         = lowest_set(event_s);

    // LED action: clear beats set-all/toggle; lowest key index wins.
    always_comb begin
        led_nxt_s = led_r;
        if (clear_s) begin
            led_nxt_s = {LED_NUM{1'b0}};
        end else if (win_s[KEY_NUM-1]) begin
            led_nxt_s = {LED_NUM{1'b1}};
        end else begin
            led_nxt_s = led_r ^ win_s[LED_NUM-1:0];
        end
    end

    // LED register, updated one cycle after the triggering event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= {LED_NUM{1'b0}};
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign led = led_r;

endmodule
